merge_2to1: RTL
===============

MERGE_2TO1 -- requirements
Module: merge_2to1

Interface
REQ-001 Parameter DATA_SIZE, default 10, width of the merged output word.
REQ-002 Parameter MAIN_SIZE, default 8, width of each lane payload; DATA_SIZE-MAIN_SIZE = 2 (lane tag).
REQ-003 Parameter BURST, default 4, max consecutive words granted to one lane while the other lane waits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 in0  input  MAIN_SIZE  head word of lane-0 source FIFO (first-word fall-through).
REQ-007 empty0  input  1  lane-0 source FIFO empty.
REQ-008 in1  input  MAIN_SIZE  head word of lane-1 source FIFO.
REQ-009 empty1  input  1  lane-1 source FIFO empty.
REQ-010 stall  input  1  downstream cannot accept a word this cycle.
REQ-011 pop0  output  1  combinational; consume lane-0 head this cycle.
REQ-012 pop1  output  1  combinational; consume lane-1 head this cycle.
REQ-013 out  output  DATA_SIZE  registered merged word {tag[1:0], payload}.
REQ-014 valid  output  1  registered; out holds a new word.
REQ-015 cnt0  output  8  lane-0 words forwarded, wraps 255->0.
REQ-016 cnt1  output  8  lane-1 words forwarded, wraps 255->0.
REQ-017 Error  output  1  sticky; pop issued against an empty lane (internal fault).

Function
REQ-018 pop0 and pop1 SHALL never be high together; no pop SHALL occur while stall=1 or while the popped lane's empty=1.
REQ-019 FSM states IDLE, SERVE0, SERVE1; burst counter bcnt (1..BURST); pointer last (lane served most recently).
REQ-020 IDLE, stall=0: both non-empty -> grant lane != last; one non-empty -> grant it; enter SERVEx, bcnt=1; none -> stay IDLE.
REQ-021 SERVEx, stall=1: no pop, state and bcnt hold.
REQ-022 SERVEx, stall=0: lane x non-empty and (bcnt<BURST or other lane empty) -> pop x, bcnt=min(bcnt+1,BURST).
REQ-023 SERVEx, stall=0, otherwise: other lane non-empty -> switch to SERVEy, pop y, bcnt=1, last=y; both empty -> IDLE, no pop.
REQ-024 Latency 1: edge sampling popx=1 SHALL load out={tag,inx} with tag 2'b00 lane 0, 2'b01 lane 1, and set valid=1.
REQ-025 Edge with no pop SHALL clear valid; out holds its last value.
REQ-026 cnt0/cnt1 SHALL increment on the same edge as the corresponding valid load, modulo 256.
REQ-027 Error SHALL set on any edge where popx=1 and emptyx=1; cleared only by reset.
REQ-028 Simultaneous stall deassert and lane arrival SHALL allow a pop in that same cycle.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, bcnt=1, last=lane 1 (lane 0 wins first tie), out=0, valid=0, cnt0=cnt1=0, Error=0.
REQ-030 reset mid-burst SHALL discard the in-flight grant; no pop asserted while reset=1.

Structure
REQ-031 Package merge_pkg SHALL hold DATA_SIZE/MAIN_SIZE defaults, tag constants TAG_L0/TAG_L1, FSM state encoding.
REQ-032 FSM, bcnt and last SHALL live in sub-module merge_arb (outputs pop0/pop1, sel); datapath, counters and Error in merge_2to1.

Verification
REQ-033 Reset, lane0 holds 0x11,0x22, lane1 empty, stall=0 -> out 0x011,0x022 on consecutive cycles one cycle after pops; cnt0=2.
REQ-034 Both lanes hold 6 words, BURST=4 -> lane-0 words 1-4, lane-1 words 1-4, lane-0 words 5-6, lane-1 words 5-6; valid continuous.
REQ-035 Lane1 only, stall high 3 cycles mid-stream -> no pops, valid=0 during stall, order preserved, tag 2'b01.
REQ-036 Lane0 streams 300 words -> cnt0 wraps to 44, cnt1=0, Error=0.
REQ-037 Assert reset during SERVE1 with both lanes non-empty -> all outputs 0 at once; after release lane 0 granted first.
REQ-038 Force empty0 high in the pop cycle (fault injection) -> Error=1 next edge and stays 1 until reset.

Source files
------------

// File: rtl/merge_pkg.sv
// Shared constants and FSM encoding for the two-lane merge block.
package merge_pkg;

    localparam int DATA_SIZE_DEF = 10;
    localparam int MAIN_SIZE_DEF = 8;
    localparam int BURST_DEF     = 4;
    localparam int TAG_W         = 2;

    localparam logic [TAG_W-1:0] TAG_L0 = 2'b00;
    localparam logic [TAG_W-1:0] TAG_L1 = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2
    } state_t;

endpackage

// File: rtl/merge_arb.sv
// Burst-limited round-robin arbiter between two FWFT source lanes.
module merge_arb
    import merge_pkg::*;
#(
    parameter int BURST = BURST_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic empty0,
    input  logic empty1,
    input  logic stall,
    output logic pop0,
    output logic pop1,
    output logic sel
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST);
    localparam logic [BW-1:0] BONE = BW'(1);

    state_t        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          last_q, last_d;
    logic          pop0_c, pop1_c;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        last_d  = last_q;
        pop0_c  = 1'b0;
        pop1_c  = 1'b0;
        if (!reset && !stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Tie goes to the lane not served most recently.
                    if (!empty0 && (empty1 || last_q)) begin
                        state_d = ST_SERVE0;
                        bcnt_d  = BONE;
                        last_d  = 1'b0;
                        pop0_c  = 1'b1;
                    end else if (!empty1) begin
                        state_d = ST_SERVE1;
                        bcnt_d  = BONE;
                        last_d  = 1'b1;
                        pop1_c  = 1'b1;
                    end
                end
                ST_SERVE0: begin
                    if (!empty0 && (bcnt_q < BMAX || empty1)) begin
                        pop0_c = 1'b1;
                        if (bcnt_q < BMAX) begin
                            bcnt_d = bcnt_q + BONE;
                        end
                    end else if (!empty1) begin
                        state_d = ST_SERVE1;
                        bcnt_d  = BONE;
                        last_d  = 1'b1;
                        pop1_c  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SERVE1: begin
                    if (!empty1 && (bcnt_q < BMAX || empty0)) begin
                        pop1_c = 1'b1;
                        if (bcnt_q < BMAX) begin
                            bcnt_d = bcnt_q + BONE;
                        end
                    end else if (!empty0) begin
                        state_d = ST_SERVE0;
                        bcnt_d  = BONE;
                        last_d  = 1'b0;
                        pop0_c  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    bcnt_d  = BONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bcnt_q  <= BONE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            last_q  <= last_d;
        end
    end

    assign pop0 = pop0_c;
    assign pop1 = pop1_c;
    assign sel  = pop1_c;

endmodule

// File: rtl/merge_2to1.sv
// Merges two tagged FIFO lanes into one registered stream with per-lane counts.
module merge_2to1
    import merge_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MAIN_SIZE = MAIN_SIZE_DEF,
    parameter int BURST     = BURST_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MAIN_SIZE-1:0] in0,
    input  logic                 empty0,
    input  logic [MAIN_SIZE-1:0] in1,
    input  logic                 empty1,
    input  logic                 stall,
    output logic                 pop0,
    output logic                 pop1,
    output logic [DATA_SIZE-1:0] out,
    output logic                 valid,
    output logic [7:0]           cnt0,
    output logic [7:0]           cnt1,
    output logic                 Error
);

    logic                 pop0_w, pop1_w, sel_w;
    logic [DATA_SIZE-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic [7:0]           cnt0_q, cnt0_d;
    logic [7:0]           cnt1_q, cnt1_d;
    logic                 error_q, error_d;

    merge_arb #(
        .BURST (BURST)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .empty0 (empty0),
        .empty1 (empty1),
        .stall  (stall),
        .pop0   (pop0_w),
        .pop1   (pop1_w),
        .sel    (sel_w)
    );

    always_comb begin
        out_d   = out_q;
        valid_d = pop0_w | pop1_w;
        cnt0_d  = cnt0_q + {7'd0, pop0_w};
        cnt1_d  = cnt1_q + {7'd0, pop1_w};
        // A pop against an empty lane means the arbiter misbehaved.
        error_d = error_q | (pop0_w & empty0) | (pop1_w & empty1);
        if (pop0_w | pop1_w) begin
            out_d = sel_w ? {TAG_L1, in1} : {TAG_L0, in0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt0_q  <= 8'd0;
            cnt1_q  <= 8'd0;
            error_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            error_q <= error_d;
        end
    end

    assign pop0  = pop0_w;
    assign pop1  = pop1_w;
    assign out   = out_q;
    assign valid = valid_q;
    assign cnt0  = cnt0_q;
    assign cnt1  = cnt1_q;
    assign Error = error_q;

endmodule
